cgra_io_channel: RTL and testbench

//  Memory-side end of one PEIO Load/Store channel of the torus CGRA array.

---
 rtl/cgra_io_channel.sv | 132 +++++++++++++
 tb/tb_cgra_io_channel.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/cgra_io_channel.sv
// Memory-side end of one PEIO Load/Store channel: streams the input buffer onto Data_Load
// and captures Data_Store into the output buffer. Optional CGRA_IO_STORE_CHECKSUM_EN adds Store_Checksum.
module cgra_io_channel #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 8,
  parameter int CWIDTH = 16
) (
  input  logic              Clk,
  input  logic              Resetn,
  input  logic              Host_Wr_En,
  input  logic [AWIDTH-1:0] Host_Wr_Addr,
  input  logic [DWIDTH-1:0] Host_Wr_Data,
  input  logic [AWIDTH-1:0] Host_Rd_Addr,
  output logic [DWIDTH-1:0] Host_Rd_Data,
  output logic              Host_Err,
  input  logic              Start,
  input  logic [CWIDTH-1:0] Compute_Cycles,
  input  logic [CWIDTH-1:0] Store_Offset,
  output logic              PE_Array_Busy,
  output logic              Done,
  output logic [DWIDTH-1:0] Data_Load,
  input  logic [DWIDTH-1:0] Data_Store
`ifdef CGRA_IO_STORE_CHECKSUM_EN
  ,
  output logic [DWIDTH-1:0] Store_Checksum
`endif
);

  localparam int DEPTH = 2 ** AWIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DWIDTH-1:0] r_ibuf [DEPTH];
  logic [DWIDTH-1:0] r_obuf [DEPTH];
  logic [CWIDTH-1:0] r_cnt;
  logic [CWIDTH-1:0] r_cycles;
  logic [CWIDTH-1:0] r_offset;
  logic [AWIDTH-1:0] r_rd_ptr;
  logic [AWIDTH-1:0] r_wr_ptr;
  logic [DWIDTH-1:0] r_data_load;
  logic [DWIDTH-1:0] r_rd_data;
  logic              r_host_err;

  logic w_start_ok;
  logic w_launch_run;
  logic w_last;
  logic w_capture;
  logic w_host_wr_ok;

  assign w_start_ok   = (r_state == ST_IDLE) && Start;
  assign w_launch_run = w_start_ok && (Compute_Cycles != '0);
  assign w_last       = (r_state == ST_RUN) && (r_cnt == r_cycles - CWIDTH'(1));
  assign w_capture    = (r_state == ST_RUN) && (r_cnt >= r_offset);
  assign w_host_wr_ok = Host_Wr_En && (r_state == ST_IDLE);

  // NOTE: next state is defaulted to the current state first so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (Start) w_state_nxt = (Compute_Cycles == '0) ? ST_DONE : ST_RUN;
      ST_RUN:  if (w_last) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_cycles    <= '0;
      r_offset    <= '0;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_data_load <= '0;
      r_rd_data   <= '0;
      r_host_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_host_err <= Host_Wr_En && (r_state != ST_IDLE);
      r_rd_data  <= r_obuf[Host_Rd_Addr];
      if (w_start_ok) begin
        r_cycles    <= Compute_Cycles;
        r_offset    <= Store_Offset;
        r_cnt       <= '0;
        r_rd_ptr    <= AWIDTH'(1);
        r_wr_ptr    <= '0;
        r_data_load <= w_launch_run ? r_ibuf[0] : '0;
      end else if (r_state == ST_RUN) begin
        // Counter holds on the last cycle so it never wraps past N-1.
        if (!w_last) r_cnt <= r_cnt + CWIDTH'(1);
        r_rd_ptr    <= r_rd_ptr + AWIDTH'(1);
        r_data_load <= w_last ? '0 : r_ibuf[r_rd_ptr];
        if (w_capture) r_wr_ptr <= r_wr_ptr + AWIDTH'(1);
      end
    end
  end

  // NOTE: buffer storage is deliberately not reset so it maps onto plain RAM.
  always_ff @(posedge Clk) begin
    if (w_host_wr_ok) r_ibuf[Host_Wr_Addr] <= Host_Wr_Data;
    if (w_capture)    r_obuf[r_wr_ptr]     <= Data_Store;
  end

`ifdef CGRA_IO_STORE_CHECKSUM_EN
  logic [DWIDTH-1:0] r_checksum;

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn)         r_checksum <= '0;
    else if (w_start_ok) r_checksum <= '0;
    else if (w_capture)  r_checksum <= r_checksum ^ Data_Store;
  end

  assign Store_Checksum = r_checksum;
`else
  // Checksum port and accumulator are absent in this build.
`endif

  assign PE_Array_Busy = (r_state == ST_RUN);
  assign Done          = (r_state == ST_DONE);
  assign Data_Load     = r_data_load;
  assign Host_Rd_Data  = r_rd_data;
  assign Host_Err      = r_host_err;

endmodule

// File: tb/tb_cgra_io_channel.sv
// Scoreboard bench for cgra_io_channel built with a 4-deep buffer so pointer wrap is exercised.
module tb_cgra_io_channel;

  localparam int DW = 32;
  localparam int AW = 2;
  localparam int CW = 16;
  localparam int DEPTH = 4;

  logic          Clk = 1'b0;
  logic          Resetn;
  logic          Host_Wr_En;
  logic [AW-1:0] Host_Wr_Addr;
  logic [DW-1:0] Host_Wr_Data;
  logic [AW-1:0] Host_Rd_Addr;
  logic [DW-1:0] Host_Rd_Data;
  logic          Host_Err;
  logic          Start;
  logic [CW-1:0] Compute_Cycles;
  logic [CW-1:0] Store_Offset;
  logic          PE_Array_Busy;
  logic          Done;
  logic [DW-1:0] Data_Load;
  logic [DW-1:0] Data_Store;
`ifdef CGRA_IO_STORE_CHECKSUM_EN
  logic [DW-1:0] Store_Checksum;
`endif

  cgra_io_channel #(.DWIDTH(DW), .AWIDTH(AW), .CWIDTH(CW)) dut (
    .Clk            (Clk),
    .Resetn         (Resetn),
    .Host_Wr_En     (Host_Wr_En),
    .Host_Wr_Addr   (Host_Wr_Addr),
    .Host_Wr_Data   (Host_Wr_Data),
    .Host_Rd_Addr   (Host_Rd_Addr),
    .Host_Rd_Data   (Host_Rd_Data),
    .Host_Err       (Host_Err),
    .Start          (Start),
    .Compute_Cycles (Compute_Cycles),
    .Store_Offset   (Store_Offset),
    .PE_Array_Busy  (PE_Array_Busy),
    .Done           (Done),
    .Data_Load      (Data_Load),
    .Data_Store     (Data_Store)
`ifdef CGRA_IO_STORE_CHECKSUM_EN
    ,
    .Store_Checksum (Store_Checksum)
`endif
  );

  always #5 Clk = ~Clk;

  int            n_checks = 0;
  int            n_pass   = 0;
  logic [DW-1:0] m_ibuf [DEPTH];
  logic [DW-1:0] m_obuf [DEPTH];
  logic [DW-1:0] m_cks;
  logic [DW-1:0] ds_pat [8];
  logic [DW-1:0] exp_load_q [$];
  logic [DW-1:0] exp_rd_q [$];

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic host_write(input int addr, input logic [DW-1:0] data);
    Host_Wr_En   = 1'b1;
    Host_Wr_Addr = AW'(addr);
    Host_Wr_Data = data;
    m_ibuf[addr] = data;
    tick();
    Host_Wr_En = 1'b0;
    check("host_err_idle_write", {31'd0, Host_Err}, 32'd0);
  endtask

  task automatic host_read(input int addr);
    Host_Rd_Addr = AW'(addr);
    exp_rd_q.push_back(m_obuf[addr]);
    tick();
    check($sformatf("rd_obuf%0d", addr), Host_Rd_Data, exp_rd_q.pop_front());
  endtask

  task automatic set_pat(input logic [DW-1:0] base);
    for (int k = 0; k < 8; k++) ds_pat[k] = base + DW'(k);
  endtask

  // poke: 1 = Start re-pulse during RUN, 2 = host write during RUN
  task automatic run(input int n, input int s, input int poke);
    int k;
    for (int i = 0; i < n; i++) begin
      exp_load_q.push_back(m_ibuf[i % DEPTH]);
      if (i >= s) m_obuf[(i - s) % DEPTH] = ds_pat[i];
    end
    m_cks = '0;
    for (int i = s; i < n; i++) m_cks ^= ds_pat[i];
    Start          = 1'b1;
    Compute_Cycles = CW'(n);
    Store_Offset   = CW'(s);
    tick();
    Start = 1'b0;
    k = 0;
    for (int c = 0; c < n + 4; c++) begin
      if (!PE_Array_Busy) break;
      if (exp_load_q.size() == 0) check("load_extra_cycle", Data_Load, 32'hFFFF_FFFF);
      else check($sformatf("load_k%0d", k), Data_Load, exp_load_q.pop_front());
      Data_Store = (k < 8) ? ds_pat[k] : '0;
      if (poke == 1) Start = (k == 1);
      if (poke == 1 && k == 1) Compute_Cycles = CW'(1);
      if (poke == 2) begin
        Host_Wr_En   = (k == 1);
        Host_Wr_Addr = '0;
        Host_Wr_Data = 32'hDEAD_BEEF;
        if (k == 2) check("host_err_pulse", {31'd0, Host_Err}, 32'd1);
        if (k == 3) check("host_err_clear", {31'd0, Host_Err}, 32'd0);
      end
      k++;
      tick();
    end
    Start      = 1'b0;
    Host_Wr_En = 1'b0;
    check("busy_cycles", DW'(k), DW'(n));
    check("done_pulse", {31'd0, Done}, 32'd1);
    check("load_queue_empty", DW'(exp_load_q.size()), 32'd0);
    exp_load_q.delete();
    if (n > 0) check("load_zero_in_done", Data_Load, 32'd0);
`ifdef CGRA_IO_STORE_CHECKSUM_EN
    check("checksum_at_done", Store_Checksum, m_cks);
`endif
    tick();
    check("done_cleared", {31'd0, Done}, 32'd0);
    check("busy_idle", {31'd0, PE_Array_Busy}, 32'd0);
  endtask

  initial begin
    Resetn = 1'b0; Host_Wr_En = 1'b0; Host_Wr_Addr = '0; Host_Wr_Data = '0;
    Host_Rd_Addr = '0; Start = 1'b0; Compute_Cycles = '0; Store_Offset = '0; Data_Store = '0;
    m_cks = '0;
    for (int i = 0; i < DEPTH; i++) begin m_ibuf[i] = '0; m_obuf[i] = '0; end
    tick();
    check("rst_busy", {31'd0, PE_Array_Busy}, 32'd0);
    check("rst_done", {31'd0, Done}, 32'd0);
    check("rst_err", {31'd0, Host_Err}, 32'd0);
    check("rst_load", Data_Load, 32'd0);
    check("rst_rd", Host_Rd_Data, 32'd0);
`ifdef CGRA_IO_STORE_CHECKSUM_EN
    check("rst_checksum", Store_Checksum, 32'd0);
`endif
    tick();
    Resetn = 1'b1;
    tick();

    host_write(0, 32'h11); host_write(1, 32'h22); host_write(2, 32'h33); host_write(3, 32'h44);
    set_pat(32'hA0);
    run(4, 0, 0);
    for (int a = 0; a < DEPTH; a++) host_read(a);

    run(6, 2, 0);
    for (int a = 0; a < DEPTH; a++) host_read(a);

    set_pat(32'hB0);
    run(6, 0, 0);
    for (int a = 0; a < DEPTH; a++) host_read(a);

    run(0, 0, 0);

    set_pat(32'hC0);
    run(4, 1, 1);
    for (int a = 0; a < DEPTH; a++) host_read(a);

    set_pat(32'hD0);
    run(4, 5, 2);
    for (int a = 0; a < DEPTH; a++) host_read(a);

    ds_pat[0] = 32'h1; ds_pat[1] = 32'h2; ds_pat[2] = 32'h4;
    run(3, 0, 0);
    host_read(0); host_read(2);

    Start = 1'b1; Compute_Cycles = CW'(6); Store_Offset = CW'(6);
    tick();
    Start = 1'b0;
    tick(); tick();
    check("busy_before_reset", {31'd0, PE_Array_Busy}, 32'd1);
    Resetn = 1'b0;
    #1;
    check("midrun_rst_busy", {31'd0, PE_Array_Busy}, 32'd0);
    check("midrun_rst_load", Data_Load, 32'd0);
    check("midrun_rst_done", {31'd0, Done}, 32'd0);
    tick();
    Resetn = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("no_done_after_reset", {31'd0, Done}, 32'd0);
    end
    m_cks = '0;
`ifdef CGRA_IO_STORE_CHECKSUM_EN
    check("checksum_after_reset", Store_Checksum, m_cks);
`endif

    set_pat(32'hE0);
    run(2, 0, 0);
    host_read(0); host_read(1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
